// File: rtl/bus_write_demux_if.sv
// CPU-to-peripheral write bus: CPU write request, peripheral busy inputs,
// registered write delivery and status back to the CPU.
interface bus_write_demux_if;
    logic        write;
    logic [15:0] id;
    logic [15:0] din;
    logic [15:0] busy;
    logic [15:0] wdata;
    logic [15:0] wstrobe;
    logic [15:0] ctrl6;
    logic [15:0] ctrl7;
    logic        stall;
    logic        err_unmapped;
    logic        err_overrun;
    logic        err_timeout;

    modport master (
        output write, id, din, busy,
        input  wdata, wstrobe, ctrl6, ctrl7, stall,
        input  err_unmapped, err_overrun, err_timeout
    );

    modport slave (
        input  write, id, din, busy,
        output wdata, wstrobe, ctrl6, ctrl7, stall,
        output err_unmapped, err_overrun, err_timeout
    );
endinterface

// File: rtl/bus_write_demux.sv
// Write-side demux: routes CPU register writes to peripherals, parking one write while busy.
// Optional macro WRITE_TIMEOUT_EN adds a hold timeout that drops the parked write.
module bus_write_demux #(
    parameter logic [15:0] WRMASK  = 16'h02CE,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    bus_write_demux_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [3:0]  hold_id_reg;
    logic [15:0] hold_din_reg;
    logic [15:0] wdata_reg, wstrobe_reg, ctrl6_reg, ctrl7_reg;
    logic        stall_reg, err_unmapped_reg, err_overrun_reg, err_timeout_reg;

    logic [3:0]  in_id;
    logic        id_errclr, id_mapped, in_busy, held_busy, timeout_hit;

    assign in_id     = bus.id[3:0];
    assign id_errclr = (bus.id == 16'h000F);
    assign id_mapped = (bus.id[15:4] == 12'd0) && (WRMASK[in_id] || id_errclr);
    assign in_busy   = bus.busy[in_id];
    assign held_busy = bus.busy[hold_id_reg];

`ifdef WRITE_TIMEOUT_EN
    logic [15:0] hold_cnt_reg;

    // Counter sits at zero in IDLE, so every HOLD entry starts a fresh count.
    assign timeout_hit = held_busy && (hold_cnt_reg == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state_reg == IDLE)
            hold_cnt_reg <= '0;
        else if (held_busy)
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.write && id_mapped && !id_errclr && in_busy) state_next = HOLD;
            HOLD: if (!held_busy || timeout_hit) state_next = IDLE;
        endcase
    end

    logic        issue_en, capture, set_unmapped, set_overrun, set_timeout;
    logic [3:0]  issue_id;
    logic [15:0] issue_din;
    logic [2:0]  clr_mask;
    logic [15:0] strobe_dec;

    always_comb begin
        issue_en     = 1'b0;
        issue_id     = in_id;
        issue_din    = bus.din;
        capture      = 1'b0;
        set_unmapped = 1'b0;
        set_overrun  = 1'b0;
        set_timeout  = 1'b0;
        clr_mask     = 3'b000;
        case (state_reg)
            IDLE: begin
                if (bus.write) begin
                    if (id_errclr)
                        clr_mask = bus.din[2:0];
                    else if (!id_mapped)
                        set_unmapped = 1'b1;
                    else if (in_busy)
                        capture = 1'b1;
                    else
                        issue_en = 1'b1;
                end
            end
            HOLD: begin
                // Any CPU write while parked is dropped, error-clear included.
                set_overrun = bus.write;
                issue_id    = hold_id_reg;
                issue_din   = hold_din_reg;
                if (!held_busy)
                    issue_en = 1'b1;
                else
                    set_timeout = timeout_hit;
            end
        endcase
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_strobe
        assign strobe_dec[gi] = issue_en && (issue_id == 4'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            hold_id_reg      <= '0;
            hold_din_reg     <= '0;
            wdata_reg        <= '0;
            wstrobe_reg      <= '0;
            ctrl6_reg        <= '0;
            ctrl7_reg        <= '0;
            stall_reg        <= 1'b0;
            err_unmapped_reg <= 1'b0;
            err_overrun_reg  <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wstrobe_reg <= strobe_dec;
            stall_reg   <= (state_next == HOLD);
            if (issue_en)      wdata_reg <= issue_din;
            if (strobe_dec[6]) ctrl6_reg <= issue_din;
            if (strobe_dec[7]) ctrl7_reg <= issue_din;
            if (capture) begin
                hold_id_reg  <= in_id;
                hold_din_reg <= bus.din;
            end
            err_unmapped_reg <= (err_unmapped_reg & ~clr_mask[0]) | set_unmapped;
            err_overrun_reg  <= (err_overrun_reg  & ~clr_mask[1]) | set_overrun;
            err_timeout_reg  <= (err_timeout_reg  & ~clr_mask[2]) | set_timeout;
        end
    end

    assign bus.wdata        = wdata_reg;
    assign bus.wstrobe      = wstrobe_reg;
    assign bus.ctrl6        = ctrl6_reg;
    assign bus.ctrl7        = ctrl7_reg;
    assign bus.stall        = stall_reg;
    assign bus.err_unmapped = err_unmapped_reg;
    assign bus.err_overrun  = err_overrun_reg;
    assign bus.err_timeout  = err_timeout_reg;
endmodule

// File: doc/bus_write_demux.md
# bus_write_demux

- Write-side counterpart of the peripheral read mux: takes CPU register writes (id, data, write strobe) and delivers them to the I2C, UART, control and sync peripherals.
- Delivery is a registered data word plus a one-cycle per-id strobe.
- Writes to a busy peripheral are held in a one-entry holding register and retried, with stall back to the CPU and sticky error flags.
- Sits between the CPU bus and the peripheral register inputs, mirroring the read path's 16-bit id map.

## Interface
Parameters:
- WRMASK, 16'h02CE, writable ids (bit n = id n): 1 i2cdata, 2 i2c control, 3 uartdata, 6 ctrl6, 7 ctrl7, 9 sync clear.
- TIMEOUT, 1024, maximum cycles a held write waits for busy to clear (used only with WRITE_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write  in  1  CPU write strobe, one cycle per write.
- id  in  16  target register id.
- din  in  16  write data.
- busy  in  16  per-id busy from peripherals; bit n = id n busy.
- wdata  out  16  registered write data to peripherals.
- wstrobe  out  16  one-hot, one-cycle write strobe; bit n = id n.
- ctrl6  out  16  latched control register, id 0x0006.
- ctrl7  out  16  latched control register, id 0x0007.
- stall  out  1  write held pending; CPU must not write while high.
- err_unmapped  out  1  sticky: write to unmapped id.
- err_overrun  out  1  sticky: write arrived while stall high.
- err_timeout  out  1  sticky: held write dropped on timeout.

## Operation
- **Reset values:** state IDLE; all outputs 0; holding register cleared.
- **Mapped id:** id < 16 and WRMASK[id] = 1. id 0x000F is the internal error-clear register and is always mapped. Every other id is unmapped.
- **IDLE, write with mapped id (not 0x000F), busy[id] = 0 — issue:**
  - wdata <= din.
  - wstrobe[id] <= 1 for one cycle.
  - id 6 also loads ctrl6 <= din; id 7 also loads ctrl7 <= din.
- **IDLE, write with mapped id, busy[id] = 1:** {id, din} captured into the holding register; stall <= 1; go to HOLD; timeout counter cleared.
- **IDLE, write to 0x000F:** din[0] clears err_unmapped, din[1] clears err_overrun, din[2] clears err_timeout. No strobe; busy is ignored.
- **IDLE, write to unmapped id:** err_unmapped <= 1; no strobe; no data change.
- **HOLD, each cycle:**
  - If busy[held id] = 0: issue the held write exactly as above, stall <= 0, go to IDLE.
  - Any write input in HOLD is ignored and sets err_overrun <= 1, including writes to 0x000F.
- **HOLD timeout (WRITE_TIMEOUT_EN only):** the counter increments each HOLD cycle with busy still high. When the counter reaches TIMEOUT-1 with busy still high:
  - go to IDLE, stall <= 0, err_timeout <= 1;
  - no strobe; wdata, ctrl6 and ctrl7 are unchanged.
- **Simultaneous:** busy clearing on the same cycle as the timeout count is reached issues the write; no error.
- **Data retention:** wdata holds its last issued value between strobes. ctrl6 and ctrl7 hold until rewritten or reset.
- **Reset mid-HOLD:** the held write is discarded with no strobe; all outputs return to reset values.

## Timing
- Inputs are sampled on the rising edge of cycle N.
- **Issue latency:** 1 cycle. wdata, wstrobe and ctrl6/7 are valid in cycle N+1; wstrobe is high for exactly that cycle.
- **Stall:** registered, high from N+1. A write in cycle N+1 is an overrun, so the CPU must leave one cycle between writes and check stall.
- **Held issue:** busy sampled low in cycle M; strobe in M+1; stall low in M+1.
- **Timeout:** at most TIMEOUT cycles spent in HOLD after entry.
- **Error flags:** set one cycle after the causing event; cleared one cycle after the 0x000F write.
- **wstrobe encoding:** never more than one bit high in any cycle.

## Configuration
- Macro: WRITE_TIMEOUT_EN.
- **Defined:** timeout counter present; HOLD exits after TIMEOUT cycles with err_timeout set.
- **Undefined:** no counter; HOLD waits for busy to clear indefinitely; err_timeout is tied 0; TIMEOUT is unused.

## Test plan
- **Basic issue:** write id=0x0003, din=0x0041, busy=0 → next cycle wdata=0x0041, wstrobe=0x0008 for one cycle, stall stays 0.
- **Control registers:** write id=0x0006, din=0xA5A5, then id=0x0007, din=0x1234, two cycles apart → ctrl6=0xA5A5 and ctrl7=0x1234, both persisting; wstrobe bits 6 then 7 pulse.
- **Hold and retry:** busy[1]=1, write id=0x0001, din=0x00FF → stall=1. Write id=0x0003 two cycles later → err_overrun=1 and no strobe. Release busy[1] at cycle 10 → wstrobe=0x0002 at cycle 11, wdata=0x00FF, stall=0.
- **Timeout (WRITE_TIMEOUT_EN, TIMEOUT=8):** busy[2] held high, write id=0x0002 → stall high for 8 cycles, then stall=0, err_timeout=1, wstrobe never asserts.
- **Unmapped and error clear:** write id=0x0004 → err_unmapped=1, no strobe. Write id=0x000F, din=0x0007 → all three error flags are 0 the next cycle.
- **Reset mid-HOLD:** busy[9]=1, write id=0x0009, assert reset two cycles later for one cycle → all outputs 0. Releasing busy[9] afterward produces no strobe.
